// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency, single-ported memory between an instruction-fetch port and a data port.
// Optional build macro ARB_ROUND_ROBIN_EN replaces data-priority/starvation arbitration with round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_en,
  output logic                  m_rw,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a requester raises req (level) with stable fields and holds it until its one-cycle ack;
  // req still high in the IDLE cycle after that ack is a new transaction. Dropping req early never cancels.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_wait_cnt, w_wait_cnt_nxt;

  logic                  r_own_d;
  logic                  r_rw;
  logic                  w_issue;
  logic                  w_grant_d;
  logic                  w_sel_rw;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_grant_d = d_req & (~i_req | ~r_last_d);
`else
  logic [3:0] r_starve;
  assign w_grant_d = d_req & (~i_req | (r_starve != 4'(STARVE_LIMIT)));
`endif

  assign w_issue     = (r_state == S_IDLE) & (i_req | d_req);
  assign w_sel_rw    = w_grant_d & d_rw;
  assign w_sel_addr  = w_grant_d ? d_addr : i_addr;
  assign w_sel_wdata = w_grant_d ? d_wdata : '0;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // WAIT spans MEM_LATENCY cycles so the edge entering DONE is the one where m_rdata is valid.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt    = S_WAIT;
        w_wait_cnt_nxt = 4'(MEM_LATENCY);
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd1) w_state_nxt = S_DONE;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      m_en    <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      r_own_d <= 1'b0;
      r_rw    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d <= 1'b0;
`else
      r_starve <= '0;
`endif
    end else begin
      busy    <= (w_state_nxt != S_IDLE);
      // The m_* registers double as the grant-time latch of the winner's request fields.
      m_en    <= w_issue;
      m_rw    <= w_issue & w_sel_rw;
      m_addr  <= w_issue ? w_sel_addr : '0;
      m_wdata <= w_issue ? w_sel_wdata : '0;
      i_ack   <= (w_state_nxt == S_DONE) & ~r_own_d;
      d_ack   <= (w_state_nxt == S_DONE) & r_own_d;
      if (w_issue) begin
        r_own_d <= w_grant_d;
        r_rw    <= w_sel_rw;
`ifdef ARB_ROUND_ROBIN_EN
        r_last_d <= w_grant_d;
`else
        if (!w_grant_d)                                  r_starve <= '0;
        else if (i_req && r_starve != 4'(STARVE_LIMIT))  r_starve <= r_starve + 4'd1;
`endif
      end
      if ((w_state_nxt == S_DONE) && !r_rw) begin
        if (r_own_d) d_rdata <= m_rdata;
        else         i_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level arbitration model, memory device and scoreboard.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int SL  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_rw;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic          i_ack, d_ack, m_en, m_rw, busy;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected memory beats {rw, addr, wdata}, pushed at grant, popped at the strobe.
  logic [64:0] exp_q[$];

  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] pend_val;
  int            pend_cnt = 0;

  int            starve = 0;
  bit            last_d = 1'b0;
  logic [DW-1:0] exp_i_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle; the memory device presents read data LAT cycles after its strobe.
  task automatic step();
    @(posedge clk);
    #1;
    if (pend_cnt > 0) begin
      pend_cnt--;
      m_rdata = (pend_cnt == 0) ? pend_val : $urandom();
    end else begin
      m_rdata = $urandom();
    end
  endtask

  task automatic mem_snoop();
    if (m_en === 1'b1) begin
      if (m_rw) mem[m_addr[5:2]] = m_wdata;
      else begin
        pend_val = mem[m_addr[5:2]];
        pend_cnt = LAT;
      end
    end
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom();
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_rw    = 1'($urandom_range(0, 1));
    d_addr  = $urandom();
    d_wdata = $urandom();
  endtask

  task automatic model_reset();
    starve   = 0;
    last_d   = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
  endtask

  // k = cycle offset inside a transaction: 0 idle/arbitration, 1 strobe, LAT+2 acknowledge.
  task automatic check_cycle(input int k, input bit own_d, input logic [64:0] beat);
    check("busy", busy, k != 0);
    check("m_en", m_en, k == 1);
    if (k == 1) check("m_beat", {m_rw, m_addr, m_wdata}, beat);
    else begin
      check("m_rw_quiet", m_rw, 0);
      check("m_addr_quiet", m_addr, 0);
      check("m_wdata_quiet", m_wdata, 0);
    end
    check("i_ack", i_ack, (k == LAT + 2) && !own_d);
    check("d_ack", d_ack, (k == LAT + 2) && own_d);
    check("i_rdata", i_rdata, exp_i_rd);
    check("d_rdata", d_rdata, exp_d_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, o_dbg_state, 0);
    check({tag, "_m_en"}, m_en, 0);
    check({tag, "_m_rw"}, m_rw, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_i_ack"}, i_ack, 0);
    check({tag, "_d_ack"}, d_ack, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Called in an IDLE cycle with requests already driven; runs one whole transaction.
  task automatic run_txn(input bit drop, output bit own_d);
    logic [64:0]   beat;
    logic [DW-1:0] rd;
    bit            is_rd;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && i_req) own_d = !last_d;
    else                own_d = d_req;
    last_d = own_d;
`else
    if (d_req && i_req) own_d = (starve < SL);
    else                own_d = d_req;
    if (!own_d)     starve = 0;
    else if (i_req) starve = (starve < 15) ? starve + 1 : 15;
`endif
    if (own_d) begin
      beat  = {d_rw, d_addr, d_wdata};
      is_rd = !d_rw;
      rd    = mem[d_addr[5:2]];
    end else begin
      beat  = {1'b0, i_addr, 32'h0};
      is_rd = 1'b1;
      rd    = mem[i_addr[5:2]];
    end
    exp_q.push_back(beat);
    @(negedge clk);
    mem_snoop();
    check_cycle(0, own_d, 0);
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      if (k == 1 && drop) begin
        if (own_d) begin
          d_req = 1'b0; d_rw = ~d_rw; d_addr = $urandom(); d_wdata = $urandom();
        end else begin
          i_req = 1'b0; i_addr = $urandom();
        end
      end
      if (k == LAT + 2 && is_rd) begin
        if (own_d) exp_d_rd = rd;
        else       exp_i_rd = rd;
      end
      @(negedge clk);
      mem_snoop();
      if (k == 1) beat = exp_q.pop_front();
      check_cycle(k, own_d, beat);
    end
  endtask

  task automatic random_phase(input int n);
    bit have_last = 1'b0;
    bit last_own  = 1'b0;
    bit own_d;
    repeat (n) begin
      step();
      if (have_last) begin
        if (last_own && d_req)       begin if ($urandom_range(0, 1) == 1) new_d(); else d_req = 1'b0; end
        else if (!last_own && i_req) begin if ($urandom_range(0, 1) == 1) new_i(); else i_req = 1'b0; end
      end
      if (!i_req && $urandom_range(0, 9) < 6) new_i();
      if (!d_req && $urandom_range(0, 9) < 6) new_d();
      if (!i_req && !d_req) begin
        @(negedge clk);
        mem_snoop();
        check_cycle(0, 1'b0, 0);
        have_last = 1'b0;
      end else begin
        run_txn($urandom_range(0, 7) == 0, own_d);
        have_last = 1'b1;
        last_own  = own_d;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit         own_d;
    logic [5:0] order;
`ifdef ARB_ROUND_ROBIN_EN
    order = 6'b010101;
`else
    order = 6'b011011;
`endif
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Both ports held continuously from reset: grant order follows the arbitration rule.
    step();
    reset = 1'b0;
    new_i();
    new_d();
    for (int t = 0; t < 6; t++) begin
      if (t > 0) begin
        step();
        if (own_d) new_d(); else new_i();
      end
      run_txn(1'b0, own_d);
      check("grant_order", own_d, order[t]);
    end

    random_phase(150);

    // Reset during WAIT of a data read: aborted, no ack, everything back to zero.
    step();
    i_req = 1'b0; d_req = 1'b1; d_rw = 1'b0; d_addr = $urandom();
    @(negedge clk); mem_snoop();
    check("abort_idle_busy", busy, 0);
    step();
    @(negedge clk); mem_snoop();
    check("abort_issue_m_en", m_en, 1);
    step();
    reset = 1'b1;
    @(negedge clk); mem_snoop();
    check("abort_wait_busy", busy, 1);
    step();
    reset = 1'b0;
    d_req = 1'b0;
    model_reset();
    @(negedge clk); mem_snoop();
    check_reset_outputs("abort");
    repeat (LAT + 3) begin
      step();
      @(negedge clk); mem_snoop();
      check_cycle(0, 1'b0, 0);
    end

    random_phase(40);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
